// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: round-robin AXI-Stream mux that holds each grant for a whole packet
module axis_packet_arbiter #(
  parameter int N_INPUTS   = 4,
  parameter int BYTE_WIDTH = 8,
  parameter int USER_WIDTH = 8
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic [N_INPUTS*BYTE_WIDTH*8-1:0]   S_AXIS_TDATA,
  input  logic [N_INPUTS*BYTE_WIDTH-1:0]     S_AXIS_TKEEP,
  input  logic [N_INPUTS*USER_WIDTH-1:0]     S_AXIS_TUSER,
  input  logic [N_INPUTS-1:0]                S_AXIS_TVALID,
  input  logic [N_INPUTS-1:0]                S_AXIS_TLAST,
  output logic [N_INPUTS-1:0]                S_AXIS_TREADY,
  output logic [BYTE_WIDTH*8-1:0]            M_AXIS_TDATA,
  output logic [BYTE_WIDTH-1:0]              M_AXIS_TKEEP,
  output logic [USER_WIDTH-1:0]              M_AXIS_TUSER,
  output logic                               M_AXIS_TLAST,
  output logic [$clog2(N_INPUTS)-1:0]        M_AXIS_TID,
  output logic                               M_AXIS_TVALID,
  input  logic                               M_AXIS_TREADY
);
  localparam int DW = BYTE_WIDTH * 8;
  localparam int IW = $clog2(N_INPUTS);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, pick, idx;
  logic [DW-1:0] data_q;
  logic [BYTE_WIDTH-1:0] keep_q;
  logic [USER_WIDTH-1:0] user_q;
  logic [IW-1:0] tid_q;
  logic tlast_q, valid_q, s_rdy, fire;
  // Round-robin search starting after last_q; the nearest requester wins
  always_comb begin
    pick = '0;
    idx = '0;
    for (int k = N_INPUTS; k >= 1; k--) begin
      idx = IW'((int'(last_q) + k) % N_INPUTS);
      if (S_AXIS_TVALID[idx]) pick = idx;
    end
  end
  assign s_rdy = (state_q == LOCKED) && (!valid_q || M_AXIS_TREADY);
  assign fire = s_rdy && S_AXIS_TVALID[grant_q];
  assign S_AXIS_TREADY = s_rdy ? (N_INPUTS'(1) << grant_q) : '0;
  // Next state: arbitrate once in IDLE, release the grant on the accepted TLAST beat
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    if (state_q == IDLE) begin
      if (|S_AXIS_TVALID) begin
        grant_d = pick;
        state_d = LOCKED;
      end
    end else if (fire && S_AXIS_TLAST[grant_q]) begin
      last_d = grant_q;
      state_d = IDLE;
    end
  end
  // Arbiter state registers; reset gives port 0 first priority
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= IW'(N_INPUTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
    end
  end
  // Output beat register: load on slave handshake, drop valid once consumed
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data_q <= '0;
      keep_q <= '0;
      user_q <= '0;
      tlast_q <= 1'b0;
      tid_q <= '0;
      valid_q <= 1'b0;
    end else if (fire) begin
      data_q <= S_AXIS_TDATA[int'(grant_q)*DW +: DW];
      keep_q <= S_AXIS_TKEEP[int'(grant_q)*BYTE_WIDTH +: BYTE_WIDTH];
      user_q <= S_AXIS_TUSER[int'(grant_q)*USER_WIDTH +: USER_WIDTH];
      tlast_q <= S_AXIS_TLAST[grant_q];
      tid_q <= grant_q;
      valid_q <= 1'b1;
    end else if (M_AXIS_TREADY) begin
      valid_q <= 1'b0;
    end
  end
  assign M_AXIS_TDATA = data_q;
  assign M_AXIS_TKEEP = keep_q;
  assign M_AXIS_TUSER = user_q;
  assign M_AXIS_TLAST = tlast_q;
  assign M_AXIS_TID = tid_q;
  assign M_AXIS_TVALID = valid_q;
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: randomized and directed traffic checked against a packet-level round-robin model
module tb_axis_packet_arbiter;
  localparam int N = 4, BW = 8, UW = 8, DW = BW * 8, IW = 2;
  logic CLK = 1'b0;
  logic RESET;
  logic [N*DW-1:0] s_data;
  logic [N*BW-1:0] s_keep;
  logic [N*UW-1:0] s_user;
  logic [N-1:0] s_valid, s_last, s_ready;
  logic [DW-1:0] m_data;
  logic [BW-1:0] m_keep;
  logic [UW-1:0] m_user;
  logic m_last, m_valid, m_ready;
  logic [IW-1:0] m_tid;

  axis_packet_arbiter #(.N_INPUTS(N), .BYTE_WIDTH(BW), .USER_WIDTH(UW)) dut (
    .CLK(CLK), .RESET(RESET),
    .S_AXIS_TDATA(s_data), .S_AXIS_TKEEP(s_keep), .S_AXIS_TUSER(s_user),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TLAST(s_last), .S_AXIS_TREADY(s_ready),
    .M_AXIS_TDATA(m_data), .M_AXIS_TKEEP(m_keep), .M_AXIS_TUSER(m_user),
    .M_AXIS_TLAST(m_last), .M_AXIS_TID(m_tid), .M_AXIS_TVALID(m_valid),
    .M_AXIS_TREADY(m_ready)
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  // sources
  bit pv[N];
  int plen[N], pidx[N];
  logic [DW-1:0] pd[N];
  logic [BW-1:0] pk[N];
  logic [UW-1:0] pu[N];
  bit pl[N];
  logic [N-1:0] en_mask;
  int v_pct, r_pct, fix_len;
  bit seq_data;
  // reference model
  bit locked, mh;
  int g, last;
  logic [82:0] mb;
  // observation of the master side
  int out_cnt;
  bit out_first;
  int first_tids[$];
  logic [10:0] obs[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(logic [N-1:0] v, int from);
    for (int k = 1; k <= N; k++)
      if (v[(from + k) % N]) return (from + k) % N;
    return 0;
  endfunction

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      if (!pv[p] && (en_mask[p] || pidx[p] != 0) && $urandom_range(1, 100) <= v_pct) begin
        if (pidx[p] == 0) plen[p] = fix_len != 0 ? fix_len : $urandom_range(1, 4);
        pd[p] = seq_data ? DW'(8'hA1 + pidx[p]) : {$urandom, $urandom};
        pk[p] = BW'($urandom_range(1, 255));
        pu[p] = UW'($urandom);
        pl[p] = (pidx[p] == plen[p] - 1);
        pv[p] = 1'b1;
      end
      s_valid[p] = pv[p];
      s_last[p] = pl[p];
      s_data[p*DW +: DW] = pd[p];
      s_keep[p*BW +: BW] = pk[p];
      s_user[p*UW +: UW] = pu[p];
    end
    m_ready = $urandom_range(1, 100) <= r_pct;
  endtask

  task automatic cycle();
    logic [N-1:0] exp_rdy;
    @(negedge CLK);
    drive();
    #1;
    exp_rdy = (locked && !(mh && !m_ready)) ? (N'(1) << g) : '0;
    chk("s_ready", s_ready, exp_rdy);
    chk("m_valid", m_valid, mh);
    if (mh) chk("m_beat", {m_tid, m_last, m_user, m_keep, m_data}, mb);
    if (m_valid && m_ready) begin
      out_cnt++;
      obs.push_back({m_tid, m_last, m_data[7:0]});
      if (out_first) first_tids.push_back(int'(m_tid));
      out_first = m_last;
    end
    if (mh && m_ready) mh = 1'b0;
    if (locked) begin
      if (exp_rdy != 0 && pv[g]) begin
        mb = {IW'(g), pl[g], pu[g], pk[g], pd[g]};
        mh = 1'b1;
        if (pl[g]) begin
          last = g;
          locked = 1'b0;
        end
      end
    end else if (s_valid != 0) begin
      g = rr_pick(s_valid, last);
      locked = 1'b1;
    end
    for (int p = 0; p < N; p++)
      if (pv[p] && s_ready[p]) begin
        pv[p] = 1'b0;
        pidx[p] = pl[p] ? 0 : pidx[p] + 1;
      end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 RESET = 1'b1;
    for (int p = 0; p < N; p++) begin
      pv[p] = 1'b0;
      pidx[p] = 0;
      s_valid[p] = 1'b0;
    end
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_beat", {m_tid, m_last, m_user, m_keep, m_data}, 0);
    chk("rst_s_ready", s_ready, 0);
    locked = 1'b0;
    mh = 1'b0;
    g = 0;
    last = N - 1;
    out_first = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int lat;
    bit ok;
    RESET = 1'b1;
    s_data = '0; s_keep = '0; s_user = '0; s_valid = '0; s_last = '0; m_ready = 1'b0;
    en_mask = '0; v_pct = 100; r_pct = 100; fix_len = 0; seq_data = 1'b0;
    for (int p = 0; p < N; p++) begin
      pv[p] = 1'b0; pidx[p] = 0; plen[p] = 1; pd[p] = '0; pk[p] = '0; pu[p] = '0; pl[p] = 1'b0;
    end
    out_cnt = 0; out_first = 1'b1; mb = '0;
    do_reset();

    // single 3-beat packet from port 2: A1, A2, A3
    en_mask = 4'b0100; fix_len = 3; seq_data = 1'b1; obs.delete(); lat = -1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      en_mask = '0;
      if (m_valid && lat < 0) lat = k;
    end
    chk("single_lat", lat, 2);
    chk("single_cnt", obs.size(), 3);
    chk("single_b0", obs.size() > 0 ? obs[0] : 11'h7ff, {2'd2, 1'b0, 8'hA1});
    chk("single_b1", obs.size() > 1 ? obs[1] : 11'h7ff, {2'd2, 1'b0, 8'hA2});
    chk("single_b2", obs.size() > 2 ? obs[2] : 11'h7ff, {2'd2, 1'b1, 8'hA3});
    seq_data = 1'b0;

    // fairness: all ports busy with 2-beat packets after reset
    do_reset();
    en_mask = 4'hf; fix_len = 2; first_tids.delete();
    run(20);
    en_mask = '0;
    for (int i = 0; i < 5; i++)
      chk("fair_order", i < first_tids.size() ? first_tids[i] : 99, (i == 4) ? 0 : i);
    run(30);

    // backpressure for 5 cycles in the middle of a 4-beat packet
    en_mask = 4'b0001; fix_len = 4; out_cnt = 0;
    cycle();
    en_mask = '0;
    run(2);
    r_pct = 0;
    run(5);
    r_pct = 100;
    run(10);
    chk("bp_cnt", out_cnt, 4);

    // wrap and skip: port 3 last served, then only port 1 requests
    en_mask = 4'b1000; fix_len = 1;
    cycle();
    en_mask = '0;
    run(5);
    first_tids.delete();
    en_mask = 4'b0010;
    cycle();
    en_mask = '0;
    run(5);
    chk("wrap_grant", first_tids.size() > 0 ? first_tids[0] : 99, 1);

    // reset in the middle of a 4-beat packet from port 1
    en_mask = 4'b0010; fix_len = 4; out_cnt = 0;
    cycle();
    en_mask = '0;
    for (int i = 0; i < 20 && out_cnt < 2; i++) cycle();
    chk("rstmid_pre", out_cnt >= 2, 1);
    do_reset();
    en_mask = 4'hf; fix_len = 1; first_tids.delete();
    cycle();
    en_mask = '0;
    run(12);
    chk("rstmid_first", first_tids.size() > 0 ? first_tids[0] : 99, 0);

    // back-to-back single-beat packets from port 0
    run(10);
    en_mask = 4'b0001; fix_len = 1; out_cnt = 0; obs.delete();
    run(20);
    en_mask = '0;
    chk("sb_cnt", out_cnt, 9);
    ok = 1'b1;
    foreach (obs[i]) if (obs[i][10:8] != 3'b001) ok = 1'b0;
    chk("sb_tid_last", ok, 1);
    run(10);

    // randomized traffic with random gaps and backpressure
    en_mask = 4'hf; fix_len = 0; v_pct = 70; r_pct = 70;
    run(2000);
    en_mask = '0; v_pct = 100; r_pct = 100;
    run(60);
    ok = !mh && !m_valid;
    for (int p = 0; p < N; p++) if (pv[p] || pidx[p] != 0) ok = 1'b0;
    chk("drain_idle", ok, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 SHALL have parameter N_INPUTS, default 4, number of slave AXI-Stream ports (legal range 2..8).
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, bytes per TDATA beat.
REQ-003 SHALL have parameter USER_WIDTH, default 8, TUSER width (legal range 1 or more).
REQ-004 SHALL have one clock; reset is asynchronous and active-high, with ports named CLK and RESET.
REQ-005 CLK  input  1  clock; all state changes on its rising edge, apart from reset assertion.
REQ-006 RESET  input  1  asynchronous active-high reset.
REQ-007 S_AXIS_TDATA  input  N_INPUTS*BYTE_WIDTH*8  per-port data, port i in slice i.
REQ-008 S_AXIS_TKEEP  input  N_INPUTS*BYTE_WIDTH  per-port byte enables.
REQ-009 S_AXIS_TUSER  input  N_INPUTS*USER_WIDTH  per-port user sideband.
REQ-010 S_AXIS_TVALID  input  N_INPUTS  per-port valid.
REQ-011 S_AXIS_TLAST  input  N_INPUTS  per-port end of packet.
REQ-012 S_AXIS_TREADY  output  N_INPUTS  per-port ready.
REQ-013 M_AXIS_TDATA / TKEEP / TUSER / TLAST  output  BYTE_WIDTH*8 / BYTE_WIDTH / USER_WIDTH / 1  registered output beat.
REQ-014 M_AXIS_TID  output  clog2(N_INPUTS)  index of the source port for the current output beat.
REQ-015 M_AXIS_TVALID  output  1; M_AXIS_TREADY  input  1.

Function
REQ-016 The arbiter SHALL use packet granularity: once granted, a port keeps the grant until its beat with TLAST=1 is accepted.
REQ-017 The FSM SHALL have two states, IDLE and LOCKED.
- IDLE: if any TVALID bit is set, latch GRANT equal to the first set port searching upward from LAST+1 modulo N_INPUTS, then go to LOCKED. Otherwise stay in IDLE.
REQ-018 In LOCKED, on a beat accepted from port GRANT with TLAST=1, the block SHALL set LAST to GRANT and return to IDLE. Otherwise it stays in LOCKED.
REQ-019 Arbitration SHALL take exactly one cycle. No S_AXIS_TREADY bit may be asserted while in IDLE.
REQ-020 S_AXIS_TREADY[i] SHALL equal (state==LOCKED) & (i==GRANT) & (!M_AXIS_TVALID | M_AXIS_TREADY). It is combinational from registered state and M_AXIS_TREADY.
REQ-021 The output register SHALL load data, keep, user, last and TID=GRANT when the slave handshake fires. M_AXIS_TVALID SHALL be set on the following edge.
REQ-022 M_AXIS_TVALID SHALL clear when M_AXIS_TREADY=1 and no new beat is loaded in the same cycle.
REQ-023 While M_AXIS_TVALID=1 and M_AXIS_TREADY=0, all M_AXIS_* outputs SHALL hold stable.
REQ-024 With M_AXIS_TREADY held at 1, LOCKED throughput SHALL be one beat per cycle. Latency from slave handshake to M_AXIS_TVALID SHALL be 1 cycle.
REQ-025 After TLAST, there SHALL be exactly one IDLE cycle (the arbitration cycle) before the next packet's first S_AXIS_TREADY.
REQ-026 A single-beat packet (TVALID and TLAST in the same beat) SHALL be handled as LOCKED then IDLE.
REQ-027 TVALID on non-granted ports SHALL be ignored. A requester dropping TVALID mid-packet SHALL keep the grant; no timeout applies.
REQ-028 The round-robin pointer SHALL wrap: LAST=N_INPUTS-1 searches from port 0.

Reset
REQ-029 RESET=1 SHALL asynchronously force the following:
- state=IDLE, GRANT=0, LAST=N_INPUTS-1 (port 0 has first priority)
- M_AXIS_TVALID=0, M_AXIS_TDATA/TKEEP/TUSER/TLAST/TID=0
- S_AXIS_TREADY=0
REQ-030 Reset mid-packet SHALL discard the partial packet and any held output beat. After release, arbitration restarts from IDLE with port 0 priority.
REQ-031 Reset release SHALL be synchronous to CLK in effect. The first arbitration occurs in the first cycle after deassertion.

Verification
REQ-032 Single requester: port 2 sends a 3-beat packet 0xA1,0xA2,0xA3 (TLAST on 0xA3) with M_AXIS_TREADY=1 -> M_AXIS_TDATA shows A1,A2,A3 on consecutive cycles, TID=2, TLAST only on A3; first M_AXIS_TVALID appears 2 cycles after TVALID rises.
REQ-033 Fairness: all 4 ports continuously valid with 2-beat packets -> grant order 0,1,2,3,0 and no interleaving of beats within a packet.
REQ-034 Backpressure: M_AXIS_TREADY=0 for 5 cycles mid-packet -> outputs frozen and S_AXIS_TREADY[GRANT]=0; resumes with no lost or duplicated beats.
REQ-035 Wrap and skip: LAST=3 and only port 1 valid -> GRANT=1, and port 0 is not selected.
REQ-036 Reset mid-packet: assert RESET after beat 2 of 4 -> M_AXIS_TVALID=0 immediately; after release, port 0 (if valid) wins first.
REQ-037 Single-beat packets back-to-back from port 0 only -> one output beat every 2 cycles, each with TLAST=1 and TID=0.
